// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronise/debounce buttons, IDLE/RUN/PAUSE sequencing, counter enable/clear.
// Optional LAP_HOLD_EN adds btn_lap/lap_hold for a frozen-display lap mode.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | counter stopped and cleared, waiting for start
// ST_RUN   | counter enabled
// ST_PAUSE | counter stopped, value retained
// (2'b11)  | illegal, returns to ST_IDLE on the next edge
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 5
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
`ifdef LAP_HOLD_EN
    input  logic       btn_lap,
    output logic       lap_hold,
`endif
    output logic       enable,
    output logic       clear,
    output logic [1:0] state
);

`ifdef LAP_HOLD_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    logic [NB-1:0]            btn_raw;
    logic [NB-1:0]            s1_q, s1_d, s2_q, s2_d;
    logic [NB-1:0]            level_q, level_d, level_dly_q, level_dly_d;
    logic [NB-1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [NB-1:0]            press;
    logic                     ss_press, clr_press, lap_press;

    state_t                   state_q, state_d;
    logic                     enable_q, enable_d;
    logic                     clear_q, clear_d;
    logic                     lap_hold_q, lap_hold_d;

`ifdef LAP_HOLD_EN
    assign btn_raw   = {btn_lap, btn_clear, btn_start_stop};
    assign lap_press = press[2];
`else
    assign btn_raw   = {btn_clear, btn_start_stop};
    assign lap_press = 1'b0;
`endif
    assign ss_press  = press[0];
    assign clr_press = press[1];

    // Debounce: level only flips after DB_CYCLES consecutive mismatching samples.
    always_comb begin
        s1_d        = btn_raw;
        s2_d        = s1_q;
        level_dly_d = level_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        for (int b = 0; b < NB; b++) begin
            if (s2_q[b] == level_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == DB_W'(DB_CYCLES - 1)) begin
                level_d[b] = s2_q[b];
                cnt_d[b]   = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + DB_W'(1);
            end
        end
        press = level_q & ~level_dly_q;
    end

    always_comb begin
        state_d    = state_q;
        clear_d    = 1'b0;
        lap_hold_d = lap_hold_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_PAUSE: begin
                if (clr_press) begin
                    state_d    = ST_IDLE;
                    clear_d    = 1'b1;
                    lap_hold_d = 1'b0;
                end else begin
                    if (ss_press) begin
                        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
                    end
                    if (lap_press) begin
                        lap_hold_d = (state_q == ST_RUN) ? ~lap_hold_q : 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lap_hold_d = 1'b0;
            end
        endcase
        enable_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            clear_q     <= 1'b0;
            lap_hold_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            enable_q    <= enable_d;
            clear_q     <= clear_d;
            lap_hold_q  <= lap_hold_d;
        end
    end

    assign enable = enable_q;
    assign clear  = clear_q;
    assign state  = state_q;
`ifdef LAP_HOLD_EN
    assign lap_hold = lap_hold_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised bench for stopwatch_ctrl against a sliding-window debounce model and a simple state model.
module tb_stopwatch_ctrl;
    localparam int DB = 4;
    localparam int HL = DB + 2;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       b_ss = 1'b0, b_clr = 1'b0, b_lap = 1'b0;
    logic       enable, clear;
    logic [1:0] state;
`ifdef LAP_HOLD_EN
    logic       lap_hold;
`endif

    stopwatch_ctrl #(.DB_CYCLES(DB), .DB_W(3)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .btn_start_stop (b_ss),
        .btn_clear      (b_clr),
`ifdef LAP_HOLD_EN
        .btn_lap        (b_lap),
        .lap_hold       (lap_hold),
`endif
        .enable         (enable),
        .clear          (clear),
        .state          (state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_clr_pulses = 0;
    int n_trans = 0;
    bit prev_clear = 1'b0;
    logic [1:0] prev_state = 2'b00;

    // Reference: raw sample history per button, debounced level, pending presses, modes.
    bit hist [3][HL];
    bit m_level [3];
    bit rose_prev [3];
    int m_state;
    bit m_clear, m_lap;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < HL; j++) hist[b][j] = 1'b0;
            m_level[b]   = 1'b0;
            rose_prev[b] = 1'b0;
        end
        m_state = 0;
        m_clear = 1'b0;
        m_lap   = 1'b0;
    endtask

    task automatic model_step();
        bit raw [3];
        bit rose_now [3];
        bit all_diff;
        int old_state;
        raw[0] = b_ss; raw[1] = b_clr; raw[2] = b_lap;
        for (int b = 0; b < 3; b++) begin
            for (int j = HL - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
            // Synchronised value seen at this edge is two samples old; flip after DB in a row differ.
            all_diff = 1'b1;
            for (int j = 2; j < HL; j++) if (hist[b][j] == m_level[b]) all_diff = 1'b0;
            rose_now[b] = all_diff && !m_level[b];
            if (all_diff) m_level[b] = !m_level[b];
        end
        old_state = m_state;
        if (rose_prev[1]) begin
            m_state = 0;
            m_clear = 1'b1;
            m_lap   = 1'b0;
        end else begin
            m_clear = 1'b0;
            if (rose_prev[0]) m_state = (old_state == 1) ? 2 : 1;
            if (rose_prev[2]) m_lap = (old_state == 1) ? !m_lap : 1'b0;
        end
        for (int b = 0; b < 3; b++) rose_prev[b] = rose_now[b];
    endtask

    task automatic cycle(input bit ss, input bit clr, input bit lap);
        @(negedge clk);
        b_ss = ss; b_clr = clr;
`ifdef LAP_HOLD_EN
        b_lap = lap;
`else
        b_lap = 1'b0;
        if (lap) b_lap = 1'b0;
`endif
        @(posedge clk);
        model_step();
        #1;
        chk("state", int'(state), m_state);
        chk("enable", int'(enable), (m_state == 1) ? 1 : 0);
        chk("clear", int'(clear), int'(m_clear));
        chk("clear_pair", int'(clear & prev_clear), 0);
`ifdef LAP_HOLD_EN
        chk("lap_hold", int'(lap_hold), int'(m_lap));
`endif
        n_clr_pulses += int'(clear);
        if (state != prev_state) n_trans++;
        prev_clear = clear;
        prev_state = state;
    endtask

    task automatic hold(input bit ss, input bit clr, input bit lap, input int n);
        repeat (n) cycle(ss, clr, lap);
    endtask

    task automatic press(input bit ss, input bit clr, input bit lap);
        hold(ss, clr, lap, 8);
        hold(1'b0, 1'b0, 1'b0, 8);
    endtask

    task automatic do_reset();
        #2;
        nrst = 1'b0;
        b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
        #1;
        chk("rst_enable", int'(enable), 0);
        chk("rst_clear", int'(clear), 0);
        chk("rst_state", int'(state), 0);
        model_reset();
        prev_clear = 1'b0;
        prev_state = 2'b00;
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        bit cur [3];
        model_reset();
        do_reset();
        hold(1'b0, 1'b0, 1'b0, 4);
        chk("t1_idle_state", int'(state), 0);

        // Single long start/stop press: one transition into RUN.
        n_trans = 0;
        hold(1'b1, 1'b0, 1'b0, 20);
        hold(1'b0, 1'b0, 1'b0, 8);
        chk("t2_state", int'(state), 1);
        chk("t2_trans", n_trans, 1);

        // Short glitch is ignored, then RUN -> PAUSE -> RUN.
        hold(1'b1, 1'b0, 1'b0, 3);
        hold(1'b0, 1'b0, 1'b0, 10);
        chk("t3_glitch", int'(state), 1);
        press(1'b1, 1'b0, 1'b0);
        chk("t3_pause", int'(state), 2);
        chk("t3_pause_en", int'(enable), 0);
        press(1'b1, 1'b0, 1'b0);
        chk("t3_run", int'(state), 1);

        // Asynchronous reset while running.
        do_reset();
        hold(1'b0, 1'b0, 1'b0, 4);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("t4_pre_pause", int'(state), 2);

        n_clr_pulses = 0;
        press(1'b0, 1'b1, 1'b0);
        chk("t4_clr_state", int'(state), 0);
        chk("t4_clr_pulses", n_clr_pulses, 1);
        n_clr_pulses = 0;
        press(1'b0, 1'b1, 1'b0);
        chk("t4_idle_pulses", n_clr_pulses, 1);

        // Simultaneous start/stop and clear: clear wins.
        press(1'b1, 1'b0, 1'b0);
        chk("t5_run", int'(state), 1);
        n_clr_pulses = 0;
        press(1'b1, 1'b1, 1'b0);
        chk("t5_state", int'(state), 0);
        chk("t5_pulses", n_clr_pulses, 1);

`ifdef LAP_HOLD_EN
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("t6_lap_on", int'(lap_hold), 1);
        chk("t6_lap_en", int'(enable), 1);
        press(1'b0, 1'b0, 1'b1);
        chk("t6_lap_off", int'(lap_hold), 0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        chk("t6_lap_clr", int'(lap_hold), 0);
        chk("t6_lap_state", int'(state), 0);
`endif

        // Random button activity mixing glitches and long holds.
        for (int b = 0; b < 3; b++) cur[b] = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(5, 0) == 0) cur[b] = !cur[b];
            cycle(cur[0], cur[1], cur[2]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
